// File: rtl/shift_deser_pkg.sv
// Shared state type, mode encodings and counter sizing for the 1/8-bit shift deserializer.
package shift_deser_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam logic MODE_BIT  = 1'b0;
    localparam logic MODE_BYTE = 1'b1;
    localparam logic DIR_MSB   = 1'b0;
    localparam logic DIR_LSB   = 1'b1;

    localparam int DEF_WORD_W = 64;

    // Counter must hold the value WORD_W itself, hence the extra bit.
    function automatic int count_w(input int word_w);
        return $clog2(word_w) + 1;
    endfunction

    localparam int CNT_W = count_w(DEF_WORD_W);

endpackage

// File: rtl/shift_deser_acc.sv
// Accumulator register and shift mux for the deserializer.
// With DESER_FLUSH_EN defined it also produces the aligned partial word for flush.
module shift_deser_acc
    import shift_deser_pkg::*;
#(
    parameter int WORD_W  = 64,
    parameter int CHUNK_W = 8,
    parameter int COUNT_W = CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic               clear,
`ifdef DESER_FLUSH_EN
    input  logic               load_flush,
    input  logic [COUNT_W-1:0] count,
    output logic [WORD_W-1:0]  flush_word,
`endif
    input  logic               width,
    input  logic               dir,
    input  logic [CHUNK_W-1:0] chunk,
    output logic [WORD_W-1:0]  acc,
    output logic [WORD_W-1:0]  shifted
);

    always_comb begin
        shifted = acc;
        if (dir == DIR_MSB) begin
            if (width == MODE_BYTE)
                shifted = {acc[WORD_W-CHUNK_W-1:0], chunk};
            else
                shifted = {acc[WORD_W-2:0], chunk[0]};
        end else begin
            if (width == MODE_BYTE)
                shifted = {chunk, acc[WORD_W-1:CHUNK_W]};
            else
                shifted = {chunk[0], acc[WORD_W-1:1]};
        end
    end

`ifdef DESER_FLUSH_EN
    logic [COUNT_W-1:0]       shamt;
    logic signed [WORD_W-1:0] acc_s;
    logic signed [WORD_W-1:0] lsb_aligned;

    // LSB-first data sits at the top of acc; slide it down, replicating the last bit received.
    assign shamt       = COUNT_W'(WORD_W) - count;
    assign acc_s       = acc;
    assign lsb_aligned = acc_s >>> shamt;
    assign flush_word  = (dir == DIR_LSB) ? lsb_aligned : acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clear)
            acc <= '0;
`ifdef DESER_FLUSH_EN
        else if (load_flush)
            acc <= flush_word;
`endif
        else if (shift_en)
            acc <= shifted;
    end

endmodule

// File: rtl/shift_deserializer_64.sv
// Serial 1/8-bit chunk to 64-bit word deserializer with a one-word output slot and a HOLD stall state.
// Optional DESER_FLUSH_EN adds in_flush to emit a partially assembled word.
module shift_deserializer_64
    import shift_deser_pkg::*;
#(
    parameter int WORD_W  = 64,
    parameter int CHUNK_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_width,
    input  logic               in_dir,
    input  logic [CHUNK_W-1:0] in_data,
`ifdef DESER_FLUSH_EN
    input  logic               in_flush,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data
);

    localparam int CW = count_w(WORD_W);

    state_t            state;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inc;
    logic [CW-1:0]     count_next;
    logic              mode_width;
    logic              mode_dir;
    logic              eff_width;
    logic              eff_dir;
    logic              beat;
    logic              first;
    logic              complete;
    logic              slot_free;
    logic              flush_go;
    logic              emit;
    logic              acc_shift;
    logic              acc_clear;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] emit_word;
`ifdef DESER_FLUSH_EN
    logic              acc_load;
    logic [WORD_W-1:0] flush_word;
`endif

    // Gated by rst_n so nothing is accepted while reset is held.
    assign in_ready   = rst_n && (state == COLLECT);
    assign beat       = in_valid && in_ready;
    assign first      = (count == '0);
    assign eff_width  = first ? in_width : mode_width;
    assign eff_dir    = first ? in_dir : mode_dir;
    assign inc        = (eff_width == MODE_BYTE) ? CW'(CHUNK_W) : CW'(1);
    assign count_next = count + inc;
    assign complete   = beat && (count_next == CW'(WORD_W));
    assign slot_free  = !out_valid || out_ready;

`ifdef DESER_FLUSH_EN
    assign flush_go  = in_flush && (state == COLLECT) && !first && !beat;
    assign emit_word = complete ? shifted : flush_word;
`else
    assign flush_go  = 1'b0;
    assign emit_word = shifted;
`endif
    assign emit = complete || flush_go;

    always_comb begin
        acc_shift = 1'b0;
        acc_clear = 1'b0;
`ifdef DESER_FLUSH_EN
        acc_load  = 1'b0;
`endif
        if (state == HOLD)
            acc_clear = out_ready;
        else if (emit && slot_free)
            acc_clear = 1'b1;
        else if (beat)
            acc_shift = 1'b1;
`ifdef DESER_FLUSH_EN
        else if (flush_go)
            acc_load = 1'b1;
`endif
    end

    shift_deser_acc #(
        .WORD_W  (WORD_W),
        .CHUNK_W (CHUNK_W),
        .COUNT_W (CW)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (acc_shift),
        .clear      (acc_clear),
`ifdef DESER_FLUSH_EN
        .load_flush (acc_load),
        .count      (count),
        .flush_word (flush_word),
`endif
        .width      (eff_width),
        .dir        (eff_dir),
        .chunk      (in_data),
        .acc        (acc),
        .shifted    (shifted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COLLECT;
            count      <= '0;
            mode_width <= MODE_BIT;
            mode_dir   <= DIR_MSB;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (beat) begin
                        count <= complete ? '0 : count_next;
                        if (first) begin
                            mode_width <= in_width;
                            mode_dir   <= in_dir;
                        end
                    end else if (flush_go) begin
                        count <= '0;
                    end

                    // A blocked word parks in acc; out_valid is already high in that case.
                    if (emit && slot_free) begin
                        out_data  <= emit_word;
                        out_valid <= 1'b1;
                    end else if (emit) begin
                        state <= HOLD;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_data <= acc;
                        state    <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule
